// File: rtl/cas_key_loader.sv
// Serial key loader: shifts an LSB-first key from NVM and commits it atomically.
// Optional parity check over the key is enabled by defining KEY_PARITY_EN.
module cas_key_loader #(
  parameter int KEY_W = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             load_abort,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             busy,
  output logic             load_err
);

`ifdef KEY_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, SHIFT, PARITY, COMMIT, LOCKED
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, SHIFT, COMMIT, LOCKED
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] sreg_q;
  logic [KEY_W-1:0] key_q;
  logic             kv_q;
  logic             accept;
  logic             last;

  assign accept = key_bit_valid & key_bit_ready;
  assign last   = (cnt_q == CNT_W'(KEY_W - 1));

`ifdef KEY_PARITY_EN
  logic err_q;
  logic par_ok;
  assign par_ok = (key_bit == ^sreg_q);
  assign load_err = err_q;
  assign key_bit_ready =
    (state_q == SHIFT) | (state_q == PARITY);
  assign busy = key_bit_ready | (state_q == COMMIT);
`else
  assign load_err = 1'b0;
  assign key_bit_ready = (state_q == SHIFT);
  assign busy = key_bit_ready | (state_q == COMMIT);
`endif

  assign keyinput  = key_q;
  assign key_valid = kv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, LOCKED: begin
        if (load_start) state_d = SHIFT;
      end
      SHIFT: begin
        if (load_abort) begin
          state_d = IDLE;
        end else if (accept && last) begin
`ifdef KEY_PARITY_EN
          state_d = PARITY;
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef KEY_PARITY_EN
      PARITY: begin
        if (load_abort)  state_d = IDLE;
        else if (accept) state_d = par_ok ? COMMIT : IDLE;
      end
`endif
      COMMIT:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      key_q  <= '0;
      kv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, LOCKED: begin
          if (load_start) begin
            cnt_q  <= '0;
            sreg_q <= '0;
            key_q  <= '0;
            kv_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (load_abort) begin
            cnt_q  <= '0;
            sreg_q <= '0;
          end else if (accept) begin
            sreg_q <= sreg_q | (KEY_W'(1) << cnt_q);
            if (!key_bit) sreg_q <= sreg_q;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
`ifdef KEY_PARITY_EN
        PARITY: begin
          if (load_abort || (accept && !par_ok)) begin
            cnt_q  <= '0;
            sreg_q <= '0;
          end
        end
`endif
        COMMIT: begin
          key_q <= sreg_q;
          kv_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef KEY_PARITY_EN
  // Error flag is sticky from a failed check until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == LOCKED)
                 && load_start) begin
      err_q <= 1'b0;
    end else if (state_q == PARITY && !load_abort
                 && accept && !par_ok) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cas_key_loader.sv
// Directed/randomized bench for cas_key_loader with a key-level reference model.
// Parity scenarios are exercised when KEY_PARITY_EN is defined.
module tb_cas_key_loader;
  localparam int KEY_W = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_start = 1'b0;
  logic             load_abort = 1'b0;
  logic             key_bit = 1'b0;
  logic             key_bit_valid = 1'b0;
  logic             key_bit_ready;
  logic [KEY_W-1:0] keyinput;
  logic             key_valid;
  logic             busy;
  logic             load_err;

  int passed = 0;
  int total  = 0;

  cas_key_loader #(.KEY_W(KEY_W), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_abort(load_abort),
    .key_bit(key_bit), .key_bit_valid(key_bit_valid),
    .key_bit_ready(key_bit_ready), .keyinput(keyinput),
    .key_valid(key_valid), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One bit through the handshake; bub: 0 none, 1 exactly one, 2 random 0..3.
  task automatic send_bit(input logic b, input int bub, input bit poke);
    int nb;
    nb = (bub == 0) ? 0 : (bub == 1) ? 1 : int'($urandom_range(0, 3));
    repeat (nb) begin
      key_bit_valid = 1'b0;
      key_bit = 1'($urandom);
      step();
      chk("bubble_kv", key_valid, 0);
      chk("bubble_key", keyinput, 0);
    end
    chk("ready", key_bit_ready, 1);
    key_bit_valid = 1'b1;
    key_bit = b;
    load_start = poke ? 1'($urandom) : 1'b0;
    step();
    key_bit_valid = 1'b0;
    load_start = 1'b0;
    chk("partial_kv", key_valid, 0);
    chk("partial_key", keyinput, 0);
  endtask

  task automatic start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_kv", key_valid, 0);
    chk("start_key", keyinput, 0);
    chk("start_err", load_err, 0);
  endtask

  task automatic load(input logic [63:0] key, input int bub,
                      input bit poke, input bit bad_par);
    start();
    for (int n = 0; n < KEY_W; n++) send_bit(key[n], bub, poke);
`ifdef KEY_PARITY_EN
    send_bit((^key) ^ bad_par, 0, 1'b0);
`endif
  endtask

  // Reference: key_valid rises exactly one edge after the final accepted bit.
  task automatic expect_commit(input logic [63:0] key, input int bub);
    int waited;
    waited = 0;
    while (!key_valid && waited < 8) begin
      step();
      waited++;
    end
    chk("latency", 64'(waited), 1);
    chk("commit_kv", key_valid, 1);
    chk("commit_key", keyinput, key);
    chk("commit_busy", busy, 0);
    chk("commit_ready", key_bit_ready, 0);
    chk("commit_err", load_err, 0);
    bub = bub;
  endtask

  initial begin
    logic [63:0] k;
    int cyc;

    #1;
    chk("rst_key", keyinput, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", key_bit_ready, 0);
    chk("rst_err", load_err, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    k = 64'hA5A5_0F0F_3C3C_FFFF;
    load(k, 0, 1'b0, 1'b0);
    expect_commit(k, 0);

    // Bubbles: every bit preceded by one idle cycle; count total edges.
    cyc = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    cyc++;
    for (int n = 0; n < KEY_W; n++) begin
      send_bit(k[n], 1, 1'b0);
      cyc += 2;
    end
`ifdef KEY_PARITY_EN
    send_bit(^k, 0, 1'b0);
    cyc++;
`endif
    step();
    cyc++;
`ifdef KEY_PARITY_EN
    chk("bubble_total", 64'(cyc), 64'(1 + 2 * KEY_W + 2));
`else
    chk("bubble_total", 64'(cyc), 64'(1 + 2 * KEY_W + 1));
`endif
    chk("bubble_kv_end", key_valid, 1);
    chk("bubble_key_end", keyinput, k);

    // Abort after 30 bits, with a bit offered on the same edge.
    k = {$urandom, $urandom};
    start();
    for (int n = 0; n < 30; n++) send_bit(k[n], 2, 1'b1);
    load_abort = 1'b1;
    key_bit_valid = 1'b1;
    step();
    load_abort = 1'b0;
    key_bit_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", key_bit_ready, 0);
    chk("abort_kv", key_valid, 0);
    chk("abort_key", keyinput, 0);
    chk("abort_err", load_err, 0);
    k = {$urandom, $urandom};
    load(k, 2, 1'b1, 1'b0);
    expect_commit(k, 2);

    // Reset in the middle of a load.
    k = {$urandom, $urandom};
    start();
    for (int n = 0; n < 40; n++) send_bit(k[n], 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_key", keyinput, 0);
    chk("mrst_kv", key_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", key_bit_ready, 0);
    chk("mrst_err", load_err, 0);
    step();
    rst_n = 1'b1;
    key_bit_valid = 1'b1;
    repeat (5) begin
      key_bit = 1'($urandom);
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_kv", key_valid, 0);
    end
    key_bit_valid = 1'b0;

    // Reload from LOCKED, abort ignored while locked.
    k = 64'h1;
    load(k, 0, 1'b0, 1'b0);
    expect_commit(k, 0);
    load_abort = 1'b1;
    step();
    load_abort = 1'b0;
    chk("locked_abort_kv", key_valid, 1);
    chk("locked_abort_key", keyinput, k);
    k = {$urandom, $urandom};
    load(k, 2, 1'b1, 1'b0);
    expect_commit(k, 2);

    repeat (3) begin
      k = {$urandom, $urandom};
      load(k, 2, 1'b1, 1'b0);
      expect_commit(k, 2);
    end

`ifdef KEY_PARITY_EN
    k = 64'h1;
    load(k, 0, 1'b0, 1'b1);
    chk("par_bad_err", load_err, 1);
    chk("par_bad_kv", key_valid, 0);
    chk("par_bad_key", keyinput, 0);
    chk("par_bad_busy", busy, 0);
    step();
    chk("par_sticky_err", load_err, 1);
    load(k, 0, 1'b0, 1'b0);
    expect_commit(k, 0);
`else
    chk("nopar_err", load_err, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
